// File: rtl/keypad_time_entry.sv
// keypad_time_entry: debounced keypad consumer that shifts BCD digits
// into an MM:SS entry register and drives four 7-segment displays.
module keypad_time_entry #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] d_in,
    input  logic       loadn,
    input  logic       clearn,
    input  logic       lock,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] count,
    output logic       key_ack,
    output logic       key_err,
    output logic [6:0] seg_mt,
    output logic [6:0] seg_mo,
    output logic [6:0] seg_st,
    output logic [6:0] seg_so
);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        CAPTURE,
        WAIT_RELEASE
    } state_t;

    localparam logic [3:0] DB_LIMIT  = 4'(DEBOUNCE_CYCLES);
    localparam logic [3:0] REL_LAST  = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] MAX_CODE  = 4'd9;
    localparam logic [2:0] MAX_COUNT = 3'd4;

    state_t     state;
    logic [3:0] db_cnt;
    logic [3:0] rel_cnt;

    logic [1:0] ln_sync;
    logic [3:0] d_sync1;
    logic [3:0] d_s;
    logic       loadn_s;

    logic       take_key;
    logic       key_bad;

    assign loadn_s = ln_sync[1];

    // The capture decision is made on the edge that enters CAPTURE so the
    // pulse and the shifted digits become visible together in that cycle.
    assign take_key = (state == DEBOUNCE) && !loadn_s && (db_cnt == DB_LIMIT);
    assign key_bad  = (d_s > MAX_CODE) || (count == MAX_COUNT);

    // Two-flop synchronizer shared by strobe and code bus.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ln_sync <= 2'b11;
            d_sync1 <= 4'd0;
            d_s     <= 4'd0;
        end else begin
            ln_sync <= {ln_sync[0], loadn};
            d_sync1 <= d_in;
            d_s     <= d_sync1;
        end
    end

    // Press/release debounce state machine.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            db_cnt  <= 4'd0;
            rel_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!loadn_s) begin
                        state  <= DEBOUNCE;
                        db_cnt <= 4'd1;
                    end
                end
                DEBOUNCE: begin
                    if (loadn_s) begin
                        state  <= IDLE;
                        db_cnt <= 4'd0;
                    end else if (db_cnt == DB_LIMIT) begin
                        state  <= CAPTURE;
                        db_cnt <= 4'd0;
                    end else begin
                        db_cnt <= db_cnt + 4'd1;
                    end
                end
                CAPTURE: begin
                    state   <= WAIT_RELEASE;
                    rel_cnt <= 4'd0;
                end
                WAIT_RELEASE: begin
                    if (!loadn_s) begin
                        rel_cnt <= 4'd0;
                    end else if (rel_cnt == REL_LAST) begin
                        state   <= IDLE;
                        rel_cnt <= 4'd0;
                    end else begin
                        rel_cnt <= rel_cnt + 4'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    db_cnt  <= 4'd0;
                    rel_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Digit shift register, digit count and result pulses; clear wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            count    <= 3'd0;
            key_ack  <= 1'b0;
            key_err  <= 1'b0;
        end else begin
            key_ack <= 1'b0;
            key_err <= 1'b0;
            if (!clearn) begin
                min_tens <= 4'd0;
                min_ones <= 4'd0;
                sec_tens <= 4'd0;
                sec_ones <= 4'd0;
                count    <= 3'd0;
            end else if (take_key && !lock) begin
                if (key_bad) begin
                    key_err <= 1'b1;
                end else begin
                    min_tens <= min_ones;
                    min_ones <= sec_tens;
                    sec_tens <= sec_ones;
                    sec_ones <= d_s;
                    count    <= count + 3'd1;
                    key_ack  <= 1'b1;
                end
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Active-low segment decode of each entered digit.
    always_comb begin
        seg_mt = seg7(min_tens);
        seg_mo = seg7(min_ones);
        seg_st = seg7(sec_tens);
        seg_so = seg7(sec_ones);
    end

endmodule
